// File: rtl/axil_to_alrdwr.sv
// AXI4-Lite slave front-end for the AL BRAM port: joins AW+W into AL write beats, answers B locally,
// forwards AR and passes R through. Define AXIL_DECERR_EN to answer out-of-range addresses with DECERR.
module axil_to_alrdwr #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_BITS      = 2,
  parameter int unsigned DATA_WIDTH     = 8 << DATA_BITS,
  parameter int unsigned MAX_OUTST_WR   = 4,
  parameter int unsigned MAX_OUTST_RD   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [DATA_WIDTH-1:0]         s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0] m_al_waddr,
  output logic [DATA_WIDTH-1:0]         m_al_wdata,
  output logic                          m_al_wvalid,
  input  logic                          m_al_wready,
  output logic [ADDR_WIDTH-DATA_BITS-1:0] m_al_araddr,
  output logic                          m_al_arid,
  output logic                          m_al_arvalid,
  input  logic                          m_al_arready,
  input  logic [DATA_WIDTH-1:0]         m_al_rdata,
  input  logic                          m_al_rvalid,
  output logic                          m_al_rready
);
  localparam int unsigned AL_AW  = ADDR_WIDTH - DATA_BITS;
  localparam int unsigned WCNT_W = $clog2(MAX_OUTST_WR + 1);
  localparam int unsigned RCNT_W = $clog2(MAX_OUTST_RD + 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  logic              rdy_en_q, rdy_en_d;
  logic              aw_full_q, aw_full_d;
  logic [AL_AW-1:0]  aw_addr_q, aw_addr_d;
  logic              w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic              ar_full_q, ar_full_d;
  logic [AL_AW-1:0]  ar_addr_q, ar_addr_d;
  logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RCNT_W-1:0] rd_cnt_q, rd_cnt_d;

  logic aw_hs, w_hs, ar_hs, b_hs;
  logic wr_join, wr_done, ar_fwd, al_ar_hs, al_r_take, oor_beat, ar_clear;
  logic unused_c;

  // Strobes and the address bits below/above the AL window carry no information here.
  assign unused_c = ^{s_axi_wstrb, s_axi_awaddr, s_axi_araddr};

  assign s_axi_awready = rdy_en_q && !aw_full_q;
  assign s_axi_wready  = rdy_en_q && !w_full_q;
  assign s_axi_arready = rdy_en_q && !ar_full_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign b_hs  = s_axi_bvalid && s_axi_bready;

  assign wr_join = aw_full_q && w_full_q && (wr_cnt_q < WCNT_W'(MAX_OUTST_WR));

  assign m_al_waddr  = aw_addr_q;
  assign m_al_wdata  = w_data_q;
  assign m_al_araddr = ar_addr_q;
  assign m_al_arid   = 1'b0;
  assign m_al_arvalid = ar_fwd;
  assign al_ar_hs    = ar_fwd && m_al_arready;

  assign s_axi_bvalid = (wr_cnt_q != '0);

  // R is a pass-through; AL beats are only honoured once the port is out of reset.
  assign al_r_take    = rdy_en_q && m_al_rvalid && s_axi_rready;
  assign m_al_rready  = rdy_en_q && s_axi_rready;
  assign s_axi_rvalid = (rdy_en_q && m_al_rvalid) || oor_beat;
  assign s_axi_rdata  = (rdy_en_q && !oor_beat) ? m_al_rdata : '0;
  assign s_axi_rresp  = oor_beat ? RESP_DECERR : RESP_OKAY;
  assign ar_clear     = al_ar_hs || (oor_beat && s_axi_rready);

`ifdef AXIL_DECERR_EN
  localparam int unsigned PTR_W = (MAX_OUTST_WR > 1) ? $clog2(MAX_OUTST_WR) : 1;

  logic                    aw_oor_q, aw_oor_d;
  logic                    ar_oor_q, ar_oor_d;
  logic [MAX_OUTST_WR-1:0] bfifo_q, bfifo_d;
  logic [PTR_W-1:0]        bwp_q, bwp_d, brp_q, brp_d;

  assign wr_done     = wr_join && (aw_oor_q || m_al_wready);
  assign m_al_wvalid = wr_join && !aw_oor_q;
  assign ar_fwd      = ar_full_q && !ar_oor_q && (rd_cnt_q < RCNT_W'(MAX_OUTST_RD));
  // Out-of-range read waits until every AL read has drained, keeping R in order.
  assign oor_beat    = rdy_en_q && ar_full_q && ar_oor_q && (rd_cnt_q == '0) && !m_al_rvalid;
  assign s_axi_bresp = (s_axi_bvalid && bfifo_q[brp_q]) ? RESP_DECERR : RESP_OKAY;

  always_comb begin
    aw_oor_d = aw_oor_q;
    ar_oor_d = ar_oor_q;
    bfifo_d  = bfifo_q;
    bwp_d    = bwp_q;
    brp_d    = brp_q;
    if (aw_hs) aw_oor_d = (s_axi_awaddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH] != '0);
    if (ar_hs) ar_oor_d = (s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH] != '0);
    if (wr_done) begin
      bfifo_d[bwp_q] = aw_oor_q;
      bwp_d = (bwp_q == PTR_W'(MAX_OUTST_WR - 1)) ? '0 : bwp_q + PTR_W'(1);
    end
    if (b_hs) brp_d = (brp_q == PTR_W'(MAX_OUTST_WR - 1)) ? '0 : brp_q + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_oor_q <= 1'b0;
      ar_oor_q <= 1'b0;
      bfifo_q  <= '0;
      bwp_q    <= '0;
      brp_q    <= '0;
    end else begin
      aw_oor_q <= aw_oor_d;
      ar_oor_q <= ar_oor_d;
      bfifo_q  <= bfifo_d;
      bwp_q    <= bwp_d;
      brp_q    <= brp_d;
    end
  end
`else
  assign wr_done     = wr_join && m_al_wready;
  assign m_al_wvalid = wr_join;
  assign ar_fwd      = ar_full_q && (rd_cnt_q < RCNT_W'(MAX_OUTST_RD));
  assign oor_beat    = 1'b0;
  assign s_axi_bresp = RESP_OKAY;
`endif

  // Holding registers and outstanding-transaction counters.
  always_comb begin
    rdy_en_d  = 1'b1;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    ar_full_d = ar_full_q;
    ar_addr_d = ar_addr_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axi_awaddr[ADDR_WIDTH-1:DATA_BITS];
    end else if (wr_done) begin
      aw_full_d = 1'b0;
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axi_wdata;
    end else if (wr_done) begin
      w_full_d = 1'b0;
    end
    if (ar_hs) begin
      ar_full_d = 1'b1;
      ar_addr_d = s_axi_araddr[ADDR_WIDTH-1:DATA_BITS];
    end else if (ar_clear) begin
      ar_full_d = 1'b0;
    end
    wr_cnt_d = wr_cnt_q + WCNT_W'(wr_done) - WCNT_W'(b_hs);
    rd_cnt_d = rd_cnt_q + RCNT_W'(al_ar_hs) - RCNT_W'(al_r_take);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q  <= 1'b0;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      ar_full_q <= 1'b0;
      ar_addr_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      rdy_en_q  <= rdy_en_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      ar_full_q <= ar_full_d;
      ar_addr_q <= ar_addr_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end
endmodule

// File: tb/tb_axil_to_alrdwr.sv
// Scoreboard bench for axil_to_alrdwr: stimulus pushes expected AL/B/R beats, a monitor pops and compares.
module tb_axil_to_alrdwr;
  localparam int unsigned AXI_AW = 32;
  localparam int unsigned AW     = 12;
  localparam int unsigned DB     = 2;
  localparam int unsigned DW     = 32;
  localparam int unsigned ALW    = AW - DB;
  localparam int unsigned TMO    = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [AXI_AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic              s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0]     s_axi_wdata, s_axi_rdata, m_al_wdata, m_al_rdata;
  logic [DW/8-1:0]   s_axi_wstrb;
  logic [1:0]        s_axi_bresp, s_axi_rresp;
  logic              s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic              s_axi_rvalid, s_axi_rready;
  logic [ALW-1:0]    m_al_waddr, m_al_araddr;
  logic              m_al_wvalid, m_al_wready, m_al_arid, m_al_arvalid, m_al_arready;
  logic              m_al_rvalid, m_al_rready;

  axil_to_alrdwr #(
    .AXI_ADDR_WIDTH(AXI_AW), .ADDR_WIDTH(AW), .DATA_BITS(DB), .DATA_WIDTH(DW),
    .MAX_OUTST_WR(4), .MAX_OUTST_RD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_al_waddr(m_al_waddr), .m_al_wdata(m_al_wdata), .m_al_wvalid(m_al_wvalid),
    .m_al_wready(m_al_wready), .m_al_araddr(m_al_araddr), .m_al_arid(m_al_arid),
    .m_al_arvalid(m_al_arvalid), .m_al_arready(m_al_arready), .m_al_rdata(m_al_rdata),
    .m_al_rvalid(m_al_rvalid), .m_al_rready(m_al_rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_lat = 2;
  int alw_cnt = 0;
  bit r_fired = 1'b0;

  logic [ALW+DW-1:0] exp_alw_q[$];
  logic [1:0]        exp_b_q[$];
  logic [ALW-1:0]    exp_alr_q[$];
  logic [DW+1:0]     exp_r_q[$];
  logic [ALW-1:0]    pend_addr_q[$];
  int                pend_t_q[$];
  logic [DW-1:0]     al_mem [1024];
  logic [ALW+DW-1:0] ew;
  logic [DW+1:0]     er;
  logic [ALW-1:0]    ea;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=unexpected required=none", name);
  endtask

  // Monitor: pops the scoreboard on every handshake the DUT presents.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (m_al_wvalid && m_al_wready) begin
        alw_cnt++;
        al_mem[m_al_waddr] = m_al_wdata;
        if (exp_alw_q.size() == 0) fail_evt("al_write_extra");
        else begin
          ew = exp_alw_q.pop_front();
          chk("al_waddr", 64'(m_al_waddr), 64'(ew[ALW+DW-1:DW]));
          chk("al_wdata", 64'(m_al_wdata), 64'(ew[DW-1:0]));
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b_q.size() == 0) fail_evt("b_extra");
        else chk("bresp", 64'(s_axi_bresp), 64'(exp_b_q.pop_front()));
      end
      if (m_al_arvalid && m_al_arready) begin
        pend_addr_q.push_back(m_al_araddr);
        pend_t_q.push_back(cyc);
        chk("al_arid", 64'(m_al_arid), 64'h0);
        if (exp_alr_q.size() == 0) fail_evt("al_read_extra");
        else begin
          ea = exp_alr_q.pop_front();
          chk("al_araddr", 64'(m_al_araddr), 64'(ea));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (m_al_rvalid) r_fired = 1'b1;
        if (exp_r_q.size() == 0) fail_evt("r_extra");
        else begin
          er = exp_r_q.pop_front();
          chk("rdata", 64'(s_axi_rdata), 64'(er[DW+1:2]));
          chk("rresp", 64'(s_axi_rresp), 64'(er[1:0]));
        end
      end
    end
  end

  // AL read side: returns memory contents rd_lat cycles after each accepted AL read.
  initial begin
    m_al_rvalid = 1'b0;
    m_al_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        m_al_rvalid = 1'b0;
        pend_addr_q.delete();
        pend_t_q.delete();
        r_fired = 1'b0;
      end else begin
        if (r_fired) begin
          m_al_rvalid = 1'b0;
          r_fired = 1'b0;
        end
        if (!m_al_rvalid && pend_addr_q.size() != 0 && cyc >= pend_t_q[0] + rd_lat) begin
          m_al_rvalid = 1'b1;
          m_al_rdata  = al_mem[pend_addr_q.pop_front()];
          void'(pend_t_q.pop_front());
        end
      end
    end
  end

  task automatic send_aw(input logic [AXI_AW-1:0] a);
    int n = 0;
    s_axi_awaddr = a;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_awready && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) fail_evt("aw_timeout");
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d);
    int n = 0;
    s_axi_wdata = d;
    s_axi_wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_wready && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) fail_evt("w_timeout");
    @(posedge clk); #1;
    s_axi_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [AXI_AW-1:0] a);
    int n = 0;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi_arready && n < TMO) begin n++; @(negedge clk); end
    if (n >= TMO) fail_evt("ar_timeout");
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_alw_q.size() + exp_b_q.size() + exp_alr_q.size() + exp_r_q.size()) != 0 && n < TMO) begin
      @(posedge clk); #1;
      n++;
    end
    if ((exp_alw_q.size() + exp_b_q.size() + exp_alr_q.size() + exp_r_q.size()) != 0)
      fail_evt("drain_timeout");
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '1; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    m_al_wready = 1'b1; m_al_arready = 1'b1;
    al_mem[4] = 32'hDEAD_BEEF;
    al_mem[8] = 32'h1234_5678;

    // Reset state and release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(s_axi_awready), 64'h0);
    chk("rst_wready", 64'(s_axi_wready), 64'h0);
    chk("rst_arready", 64'(s_axi_arready), 64'h0);
    chk("rst_bvalid", 64'(s_axi_bvalid), 64'h0);
    chk("rst_bresp", 64'(s_axi_bresp), 64'h0);
    chk("rst_rvalid", 64'(s_axi_rvalid), 64'h0);
    chk("rst_rdata", 64'(s_axi_rdata), 64'h0);
    chk("rst_al_wvalid", 64'(m_al_wvalid), 64'h0);
    chk("rst_al_arvalid", 64'(m_al_arvalid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_awready", 64'(s_axi_awready), 64'h1);
    chk("rel_wready", 64'(s_axi_wready), 64'h1);
    chk("rel_arready", 64'(s_axi_arready), 64'h1);

    // AW first, W five cycles later; unaligned address rounds down to word 0x41
    exp_alw_q.push_back({10'h041, 32'h1111_2222});
    exp_b_q.push_back(2'b00);
    send_aw(32'h0000_0107);
    repeat (4) @(posedge clk);
    #1;
    chk("t1_no_early_wvalid", 64'(m_al_wvalid), 64'h0);
    send_w(32'h1111_2222);
    chk("t1_wvalid_lat", 64'(m_al_wvalid), 64'h1);
    @(posedge clk); #1;
    chk("t1_bvalid", 64'(s_axi_bvalid), 64'h1);
    wait_empty();

`ifndef AXIL_DECERR_EN
    // Upper address bits alias onto the AL window
    exp_alw_q.push_back({10'h042, 32'hCAFE_0001});
    exp_b_q.push_back(2'b00);
    fork
      send_aw(32'hFFFF_F108);
      send_w(32'hCAFE_0001);
    join
    wait_empty();
`endif

    // Eight back-to-back writes against a stalled B channel
    s_axi_bready = 1'b0;
    alw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      exp_alw_q.push_back({10'(128 + i), 32'(32'hA0 + i)});
      exp_b_q.push_back(2'b00);
    end
    fork
      for (int i = 0; i < 8; i++) send_aw(32'(32'h200 + 4 * i));
      for (int j = 0; j < 8; j++) send_w(32'(32'hA0 + j));
      begin
        repeat (30) @(posedge clk);
        #1;
        chk("t2_al_writes_stalled", 64'(alw_cnt), 64'd4);
        chk("t2_awready_low", 64'(s_axi_awready), 64'h0);
        chk("t2_wready_low", 64'(s_axi_wready), 64'h0);
        chk("t2_bvalid", 64'(s_axi_bvalid), 64'h1);
        s_axi_bready = 1'b1;
      end
    join
    wait_empty();
    chk("t2_al_writes_total", 64'(alw_cnt), 64'd8);

    // Read 0x10 with R held off for several cycles
    s_axi_rready = 1'b0;
    exp_alr_q.push_back(10'h004);
    exp_r_q.push_back({32'hDEAD_BEEF, 2'b00});
    send_ar(32'h0000_0010);
    n = 0;
    while (!s_axi_rvalid && n < TMO) begin @(posedge clk); #1; n++; end
    if (!s_axi_rvalid) fail_evt("t3_rvalid_timeout");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("t3_rvalid_hold", 64'(s_axi_rvalid), 64'h1);
      chk("t3_rdata_hold", 64'(s_axi_rdata), 64'hDEAD_BEEF);
    end
    s_axi_rready = 1'b1;
    wait_empty();

    // Write and read in the same cycle with AL write side busy
    m_al_wready = 1'b0;
    exp_alw_q.push_back({10'h0C0, 32'h5555_AAAA});
    exp_b_q.push_back(2'b00);
    exp_alr_q.push_back(10'h008);
    exp_r_q.push_back({32'h1234_5678, 2'b00});
    fork
      send_aw(32'h0000_0300);
      send_w(32'h5555_AAAA);
      send_ar(32'h0000_0020);
    join
    repeat (2) @(posedge clk);
    #1;
    chk("t4_wr_pending", 64'(m_al_wvalid), 64'h1);
    m_al_wready = 1'b1;
    wait_empty();

`ifdef AXIL_DECERR_EN
    // Out-of-range read queued behind two AL reads, never forwarded
    rd_lat = 8;
    exp_alr_q.push_back(10'h008);
    exp_r_q.push_back({32'h1234_5678, 2'b00});
    exp_alr_q.push_back(10'h004);
    exp_r_q.push_back({32'hDEAD_BEEF, 2'b00});
    exp_r_q.push_back({32'h0, 2'b11});
    send_ar(32'h0000_0020);
    send_ar(32'h0000_0010);
    send_ar(32'h0001_0000);
    wait_empty();
    rd_lat = 2;

    // Out-of-range write gets DECERR in order ahead of a normal write
    exp_b_q.push_back(2'b11);
    exp_b_q.push_back(2'b00);
    exp_alw_q.push_back({10'h100, 32'h0000_0077});
    fork
      begin send_aw(32'h0002_0000); send_aw(32'h0000_0400); end
      begin send_w(32'hBAD0_BAD0); send_w(32'h0000_0077); end
    join
    wait_empty();
`endif

    // Reset asserted with three B responses owed
    s_axi_bready = 1'b0;
    alw_cnt = 0;
    for (int i = 0; i < 3; i++) exp_alw_q.push_back({10'(16 + i), 32'(32'h3000 + i)});
    fork
      for (int i = 0; i < 3; i++) send_aw(32'(32'h40 + 4 * i));
      for (int j = 0; j < 3; j++) send_w(32'(32'h3000 + j));
    join
    n = 0;
    while (alw_cnt < 3 && n < TMO) begin @(posedge clk); #1; n++; end
    if (alw_cnt < 3) fail_evt("t6_fill_timeout");
    @(posedge clk); #1;
    chk("t6_bvalid_pre", 64'(s_axi_bvalid), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bvalid", 64'(s_axi_bvalid), 64'h0);
    chk("t6_rst_awready", 64'(s_axi_awready), 64'h0);
    chk("t6_rst_al_wvalid", 64'(m_al_wvalid), 64'h0);
    chk("t6_rst_al_arvalid", 64'(m_al_arvalid), 64'h0);
    chk("t6_rst_rvalid", 64'(s_axi_rvalid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_rel_awready", 64'(s_axi_awready), 64'h1);
    chk("t6_rel_wready", 64'(s_axi_wready), 64'h1);
    chk("t6_rel_arready", 64'(s_axi_arready), 64'h1);
    chk("t6_rel_bvalid", 64'(s_axi_bvalid), 64'h0);
    s_axi_bready = 1'b1;
    exp_alw_q.push_back({10'h020, 32'h0000_0006});
    exp_b_q.push_back(2'b00);
    fork
      send_aw(32'h0000_0080);
      send_w(32'h0000_0006);
    join
    wait_empty();
    chk("end_bvalid_idle", 64'(s_axi_bvalid), 64'h0);
    chk("end_rvalid_idle", 64'(s_axi_rvalid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
